cache_tag_ctrl: RTL and testbench
=================================

Name: cache_tag_ctrl

Overview:
- Lookup/replacement sequencer for a 4-way, 128-set cache built from four tag_array instances (20-bit tag, asynchronous read, synchronous write).
- Accepts one lookup request at a time, compares tags, and tracks valid, dirty and tree-PLRU state per set.
- On a miss, runs writeback and refill handshakes toward the memory side, then installs the new tag.
- Sits between the CPU-side cache front end and the tag arrays/memory interface; the data arrays are sequenced elsewhere using resp_way.

Parameters:
TAG_W, 20, tag width = ADDR_W - IDX_W - OFF_W
IDX_W, 7, set index width (128 sets)
OFF_W, 5, line offset width (32-byte line)
ADDR_W, 32, physical address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  lookup request
req_ready  output  1  controller can accept a request
req_addr  input  ADDR_W  request address
req_wen  input  1  request is a store; marks line dirty
resp_valid  output  1  lookup result valid
resp_ready  input  1  front end accepts result
resp_hit  output  1  1 = hit, 0 = miss serviced by refill
resp_way  output  2  way holding the line
ta_raddr  output  IDX_W  read index, shared by the 4 tag arrays
ta_rdata  input  4*TAG_W  packed read tags; way w at [w*TAG_W +: TAG_W]
ta_waddr  output  IDX_W  write index
ta_wen  output  4  per-way write enable
ta_wdata  output  TAG_W  tag to write
wb_valid  output  1  writeback request
wb_ready  input  1  memory accepts writeback
wb_addr  output  ADDR_W  {victim_tag, index, OFF_W'b0}
wb_done  input  1  writeback complete (1-cycle pulse)
rf_valid  output  1  refill request
rf_ready  input  1  memory accepts refill
rf_addr  output  ADDR_W  {req_tag, index, OFF_W'b0}
rf_done  input  1  refill data written (1-cycle pulse)

Behaviour:
- Address split: tag = addr[31:12], index = addr[11:5].
- The request address and req_wen are latched when req_valid && req_ready.
- ta_raddr is always the latched index. ta_waddr equals ta_raddr.
- Per-set state lives in registers: valid[4], dirty[4], plru[3].
- While rst is low: all per-set state = 0, state = IDLE, and all outputs = 0 except req_ready = 1.
- Reset asserted mid-operation aborts any handshake immediately.
- FSM states and transitions:
  - IDLE: req_ready = 1. On accept, go to LOOKUP.
  - LOOKUP: hit[w] = valid[w] && (ta_rdata tag == req_tag).
    - Any hit: lowest-numbered hitting way wins. Update PLRU; if req_wen, set dirty[w]. Go to RESP with resp_hit = 1.
    - Miss, victim selection: lowest-numbered invalid way if any, else the PLRU victim.
    - Miss, next state: if the victim is valid && dirty, go to WB; else go to RF.
  - WB: wb_valid = 1 and wb_addr stable until wb_ready. Then go to WB_WAIT.
  - WB_WAIT: wait for wb_done, then go to RF. wb_done in any other state is ignored.
  - RF: rf_valid = 1 and rf_addr stable until rf_ready. Then go to RF_WAIT.
  - RF_WAIT: on rf_done, in the same cycle:
    - pulse ta_wen[victim] = 1 with ta_wdata = req_tag;
    - set valid[victim] = 1 and dirty[victim] = req_wen;
    - update PLRU toward the victim.
    - Then go to RESP with resp_hit = 0 and resp_way = victim.
  - RESP: resp_valid held until resp_ready, then go to IDLE. Outputs are registered and stable while resp_valid is high.
- PLRU encoding, 3 bits per set:
  - b0 = 0 selects ways 0-1, b0 = 1 selects ways 2-3.
  - b1 picks within ways 0-1 (0 = way0); b2 picks within ways 2-3 (0 = way2).
  - Access to way w: b0 = ~w[1]; if w[1] = 0 then b1 = ~w[0], else b2 = ~w[0].
- Latency:
  - Hit: accept at cycle 0, LOOKUP at cycle 1, resp_valid at cycle 2.
  - Miss: 2 cycles plus handshake time.
- Single outstanding request; no back-to-back acceptance. req_ready is 0 in all states other than IDLE.
- ta_wen is never asserted outside RF_WAIT and is at most one-hot.

Decomposition:
- Shared package cache_pkg:
  - TAG_W, IDX_W, OFF_W, ADDR_W, WAYS = 4;
  - FSM state enum {IDLE, LOOKUP, WB, WB_WAIT, RF, RF_WAIT, RESP};
  - address field extraction functions.
- Sub-module plru_tree_4, combinational:
  - inputs: plru[2:0], access_way, access_en;
  - outputs: victim_way[1:0], plru_next[2:0].

Test Plan:
- Cold miss on empty cache: addr 0x0000_1020, rf_done at +3 cycles -> no wb_valid; rf_addr = 0x0000_1020; ta_wen = 4'b0001, ta_waddr = 1, ta_wdata = 0x00001; resp_hit = 0, resp_way = 0.
- Re-read same address -> resp_valid exactly 2 cycles after accept; resp_hit = 1, resp_way = 0; no wb_valid or rf_valid.
- Fill set 1 with tags 1..4, then access tag 5 -> victim = PLRU way (way 0 after access order 0,1,2,3); no writeback since all lines are clean; ta_wen = 4'b0001.
- Store to tag 1 (way 0) followed by a miss whose victim is way 0 -> wb_valid with wb_addr = 0x0000_1020; after wb_done, rf_valid; dirty[0] = req_wen of the new request.
- wb_ready and rf_ready held low for 10 cycles -> wb_valid/rf_valid stay high and addresses stay stable; resp_valid held 5 cycles with resp_ready = 0 and data unchanged.
- rst pulled low during RF_WAIT -> immediate IDLE, req_ready = 1, no ta_wen pulse; re-lookup of the same address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and address field helpers for the cache tag controller.
package cache_pkg;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 7;
  localparam int OFF_W  = 5;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAYS   = 4;
  localparam int SETS   = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, WB_WAIT, RF, RF_WAIT, RESP} state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_tag_ctrl_plru.sv
// 4-way tree pseudo-LRU: victim lookup and access update for one set, purely combinational.
module plru_tree_4 (
  input  logic [2:0] plru,
  input  logic [1:0] access_way,
  input  logic       access_en,
  output logic [1:0] victim_way,
  output logic [2:0] plru_next
);
  assign victim_way = plru[0] ? {1'b1, plru[2]} : {1'b0, plru[1]};

  // Each touched node is turned to point away from the accessed way.
  always_comb begin
    plru_next = plru;
    if (access_en) begin
      plru_next[0] = ~access_way[1];
      if (!access_way[1]) plru_next[1] = ~access_way[0];
      else                plru_next[2] = ~access_way[0];
    end
  end
endmodule

// File: rtl/cache_tag_ctrl.sv
// Lookup/replacement sequencer for a 4-way, 128-set cache: tag compare, valid/dirty/PLRU
// tracking, and writeback/refill handshakes on a miss.
//
// state   | meaning
// IDLE    | ready for a request
// LOOKUP  | compare tags of the latched set
// WB      | writeback request pending acceptance
// WB_WAIT | waiting for writeback completion
// RF      | refill request pending acceptance
// RF_WAIT | waiting for refill completion, then install tag
// RESP    | holding the lookup result
module cache_tag_ctrl
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_wen,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_hit,
  output logic [1:0]            resp_way,
  output logic [IDX_W-1:0]      ta_raddr,
  input  logic [WAYS*TAG_W-1:0] ta_rdata,
  output logic [IDX_W-1:0]      ta_waddr,
  output logic [WAYS-1:0]       ta_wen,
  output logic [TAG_W-1:0]      ta_wdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_W-1:0]     wb_addr,
  input  logic                  wb_done,
  output logic                  rf_valid,
  input  logic                  rf_ready,
  output logic [ADDR_W-1:0]     rf_addr,
  input  logic                  rf_done
);
  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [WAYS-1:0]     r_valid [SETS];
  logic [WAYS-1:0]     r_dirty [SETS];
  logic [2:0]          r_plru  [SETS];
  logic [1:0]          r_victim;
  logic [TAG_W-1:0]    r_victim_tag;
  logic                r_resp_hit;
  logic [1:0]          r_resp_way;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [WAYS-1:0]     w_hit;
  logic [1:0]          w_hit_way, w_inv_way, w_plru_victim, w_miss_victim, w_acc_way;
  logic                w_inv_any, w_acc_en, w_fill;
  logic [2:0]          w_plru_next;
  logic [TAG_W-1:0]    w_victim_tag;

  assign w_idx = addr_idx(r_addr);
  assign w_tag = addr_tag(r_addr);

  always_comb begin
    w_hit = '0;
    for (int w = 0; w < WAYS; w++)
      w_hit[w] = r_valid[w_idx][w] && (ta_rdata[w*TAG_W +: TAG_W] == w_tag);
  end

  // Descending scan so the lowest-numbered candidate is the one left standing.
  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (w_hit[w])            w_hit_way = 2'(w);
      if (!r_valid[w_idx][w])  w_inv_way = 2'(w);
    end
  end

  assign w_inv_any     = ~&r_valid[w_idx];
  assign w_miss_victim = w_inv_any ? w_inv_way : w_plru_victim;
  assign w_victim_tag  = ta_rdata[w_miss_victim*TAG_W +: TAG_W];
  assign w_fill        = (r_state == RF_WAIT) && rf_done;
  assign w_acc_way     = (r_state == LOOKUP) ? w_hit_way : r_victim;
  assign w_acc_en      = ((r_state == LOOKUP) && (|w_hit)) || w_fill;

  plru_tree_4 u_plru (
    .plru       (r_plru[w_idx]),
    .access_way (w_acc_way),
    .access_en  (w_acc_en),
    .victim_way (w_plru_victim),
    .plru_next  (w_plru_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = LOOKUP;
      LOOKUP: begin
        if (|w_hit)
          w_state_nxt = RESP;
        else if (r_valid[w_idx][w_miss_victim] && r_dirty[w_idx][w_miss_victim])
          w_state_nxt = WB;
        else
          w_state_nxt = RF;
      end
      WB:      if (wb_ready)   w_state_nxt = WB_WAIT;
      WB_WAIT: if (wb_done)    w_state_nxt = RF;
      RF:      if (rf_ready)   w_state_nxt = RF_WAIT;
      RF_WAIT: if (rf_done)    w_state_nxt = RESP;
      RESP:    if (resp_ready) w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_victim     <= '0;
      r_victim_tag <= '0;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if ((r_state == IDLE) && req_valid) begin
        r_addr <= req_addr;
        r_wen  <= req_wen;
      end
      if (r_state == LOOKUP) begin
        if (|w_hit) begin
          r_resp_hit <= 1'b1;
          r_resp_way <= w_hit_way;
          if (r_wen) r_dirty[w_idx][w_hit_way] <= 1'b1;
        end else begin
          r_resp_hit   <= 1'b0;
          r_resp_way   <= w_miss_victim;
          r_victim     <= w_miss_victim;
          r_victim_tag <= w_victim_tag;
        end
      end
      if (w_acc_en) r_plru[w_idx] <= w_plru_next;
      if (w_fill) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= r_wen;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_hit   = r_resp_hit;
  assign resp_way   = r_resp_way;
  assign ta_raddr   = w_idx;
  assign ta_waddr   = w_idx;
  assign ta_wen     = w_fill ? (4'b0001 << r_victim) : 4'b0000;
  assign ta_wdata   = w_tag;
  assign wb_valid   = (r_state == WB);
  assign wb_addr    = line_addr(r_victim_tag, w_idx);
  assign rf_valid   = (r_state == RF);
  assign rf_addr    = line_addr(w_tag, w_idx);
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Bench for cache_tag_ctrl: behavioural set/PLRU model, tag-array and memory-side responders.
module tb_cache_tag_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 0, req_wen = 0, resp_ready = 0;
  logic wb_ready = 0, wb_done = 0, rf_ready = 0, rf_done = 0;
  logic [31:0] req_addr = '0;
  logic req_ready, resp_valid, resp_hit, wb_valid, rf_valid;
  logic [1:0] resp_way;
  logic [6:0] ta_raddr, ta_waddr;
  logic [3:0] ta_wen;
  logic [19:0] ta_wdata;
  logic [79:0] ta_rdata;
  logic [31:0] wb_addr, rf_addr;

  always #5 clk = ~clk;

  cache_tag_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_way(resp_way), .ta_raddr(ta_raddr), .ta_rdata(ta_rdata), .ta_waddr(ta_waddr),
    .ta_wen(ta_wen), .ta_wdata(ta_wdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_done(wb_done), .rf_valid(rf_valid), .rf_ready(rf_ready),
    .rf_addr(rf_addr), .rf_done(rf_done)
  );

  // Tag arrays: asynchronous read, synchronous write.
  logic [19:0] tag_mem [4][128];
  always @(posedge clk)
    for (int w = 0; w < 4; w++)
      if (ta_wen[w]) tag_mem[w][ta_waddr] <= ta_wdata;
  always_comb begin
    ta_rdata = '0;
    for (int w = 0; w < 4; w++) ta_rdata[w*20 +: 20] = tag_mem[w][ta_raddr];
  end

  // Model of per-set contents: which tag each way holds, and the three PLRU tree nodes.
  bit          m_valid [128][4];
  bit          m_dirty [128][4];
  logic [19:0] m_tag   [128][4];
  bit          m_n0 [128], m_n1 [128], m_n2 [128];

  logic [6:0]  exp_idx;
  logic [19:0] exp_tag;
  logic [1:0]  exp_way;
  logic [31:0] exp_wb_addr, exp_rf_addr;
  bit          exp_hit, exp_wb;

  bit busy = 0, in_rst = 1;
  int start_req = 0, end_req = 0;
  int e_lat = 0;
  bit e_timeout = 0, e_abort = 0;

  bit          lit_on = 0, lit_hit = 0, lit_wb_on = 0;
  logic [1:0]  lit_way;
  logic [31:0] lit_rf, lit_wb;
  logic [3:0]  lit_wen;
  logic [6:0]  lit_waddr;
  logic [19:0] lit_wdata;

  int n_checks = 0, n_pass = 0;

  function automatic int plru_victim(input logic [6:0] idx);
    if (m_n0[idx]) return m_n2[idx] ? 3 : 2;
    return m_n1[idx] ? 1 : 0;
  endfunction

  task automatic touch(input logic [6:0] idx, input int w);
    m_n0[idx] = (w < 2);
    if (w < 2) m_n1[idx] = (w == 0);
    else       m_n2[idx] = (w == 2);
  endtask

  task automatic predict(input logic [31:0] a);
    logic [6:0] idx;
    logic [19:0] tag;
    int v;
    idx = a[11:5];
    tag = a[31:12];
    exp_idx = idx; exp_tag = tag; exp_hit = 0; exp_way = 0;
    for (int w = 3; w >= 0; w--)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) begin exp_hit = 1; exp_way = 2'(w); end
    if (!exp_hit) begin
      v = -1;
      for (int w = 3; w >= 0; w--) if (!m_valid[idx][w]) v = w;
      if (v < 0) v = plru_victim(idx);
      exp_way = 2'(v);
    end
    exp_wb      = !exp_hit && m_valid[idx][exp_way] && m_dirty[idx][exp_way];
    exp_wb_addr = {m_tag[idx][exp_way], idx, 5'b0};
    exp_rf_addr = {tag, idx, 5'b0};
  endtask

  task automatic commit(input logic wen);
    touch(exp_idx, int'(exp_way));
    if (exp_hit) begin
      if (wen) m_dirty[exp_idx][exp_way] = 1;
    end else begin
      m_valid[exp_idx][exp_way] = 1;
      m_dirty[exp_idx][exp_way] = wen;
      m_tag[exp_idx][exp_way]   = exp_tag;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 128; s++) begin
      m_n0[s] = 0; m_n1[s] = 0; m_n2[s] = 0;
      for (int w = 0; w < 4; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Compare process: runs 1 time unit after every falling edge.
  int start_seen = 0, end_seen = 0, wen_n = 0;
  bit saw_wb = 0, saw_rf = 0, obs_hit = 0;
  logic [1:0]  obs_way = 0;
  logic [31:0] obs_wb_addr = 0, obs_rf_addr = 0;
  logic [3:0]  obs_wen = 0;
  logic [6:0]  obs_waddr = 0;
  logic [19:0] obs_wdata = 0;

  always @(negedge clk) begin
    #1;
    if (start_req != start_seen) begin
      start_seen = start_req;
      saw_wb = 0; saw_rf = 0; wen_n = 0; obs_hit = 0; obs_way = 0;
      obs_wb_addr = 0; obs_rf_addr = 0; obs_wen = 0; obs_waddr = 0; obs_wdata = 0;
    end
    if (in_rst) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_valids", {resp_valid, wb_valid, rf_valid}, 0);
      chk("rst_ta_wen", ta_wen, 0);
      chk("rst_resp", {resp_hit, resp_way}, 0);
      chk("rst_wb_addr", wb_addr, 0);
      chk("rst_rf_addr", rf_addr, 0);
      chk("rst_ta_idx", {ta_raddr, ta_waddr}, 0);
      chk("rst_ta_wdata", ta_wdata, 0);
    end else begin
      chk("req_ready", req_ready, !busy);
      if (busy) chk("ta_raddr", ta_raddr, exp_idx);
      else      chk("idle_quiet", {resp_valid, wb_valid, rf_valid, ta_wen}, 0);
      if (resp_valid) begin
        chk("resp_hit", resp_hit, exp_hit);
        chk("resp_way", resp_way, exp_way);
        obs_hit = resp_hit; obs_way = resp_way;
      end
      if (wb_valid) begin
        saw_wb = 1;
        chk("wb_addr", wb_addr, exp_wb_addr);
        obs_wb_addr = wb_addr;
      end
      if (rf_valid) begin
        saw_rf = 1;
        chk("rf_addr", rf_addr, exp_rf_addr);
        obs_rf_addr = rf_addr;
      end
      if (ta_wen != 0) begin
        wen_n++;
        chk("ta_wen", ta_wen, 32'd1 << exp_way);
        chk("ta_waddr", ta_waddr, exp_idx);
        chk("ta_wdata", ta_wdata, exp_tag);
        obs_wen = ta_wen; obs_waddr = ta_waddr; obs_wdata = ta_wdata;
      end
    end
    if (end_req != end_seen) begin
      end_seen = end_req;
      chk("timeout", e_timeout, 0);
      if (e_abort) chk("abort_wen_pulses", wen_n, 0);
      else begin
        chk("wb_seen", saw_wb, exp_wb);
        chk("rf_seen", saw_rf, !exp_hit);
        chk("wen_pulses", wen_n, exp_hit ? 0 : 1);
        if (exp_hit) chk("hit_latency", e_lat, 2);
      end
      if (lit_on) begin
        chk("lit_hit", obs_hit, lit_hit);
        chk("lit_way", obs_way, lit_way);
        if (!lit_hit) begin
          chk("lit_rf_addr", obs_rf_addr, lit_rf);
          chk("lit_ta_wen", obs_wen, lit_wen);
          chk("lit_ta_waddr", obs_waddr, lit_waddr);
          chk("lit_ta_wdata", obs_wdata, lit_wdata);
        end
        if (lit_wb_on) chk("lit_wb_addr", obs_wb_addr, lit_wb);
      end
    end
  end

  task automatic lit(input bit h, input logic [1:0] w, input logic [31:0] rf, input logic [3:0] wen,
                     input logic [6:0] wa, input logic [19:0] wd, input bit wbo, input logic [31:0] wb);
    lit_on = 1; lit_hit = h; lit_way = w; lit_rf = rf; lit_wen = wen;
    lit_waddr = wa; lit_wdata = wd; lit_wb_on = wbo; lit_wb = wb;
  endtask

  task automatic txn(input logic [31:0] addr, input logic wen, input int wb_lat, input int rf_lat,
                     input int rfd, input int hold, input bit abort);
    int cyc, wb_cnt, rf_cnt, wbd, rfdc, resp_cnt;
    bit wb_acc, rf_acc, done;
    cyc = 0; wb_cnt = 0; rf_cnt = 0; wbd = 0; rfdc = 0; resp_cnt = 0;
    wb_acc = 0; rf_acc = 0; done = 0;
    predict(addr);
    @(negedge clk);
    start_req++;
    e_timeout = 0; e_abort = 0; e_lat = 0;
    req_valid = 1; req_addr = addr; req_wen = wen;
    @(posedge clk);
    busy = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      req_valid = 0; wb_ready = 0; rf_ready = 0; wb_done = 0; rf_done = 0; resp_ready = 0;
      if (resp_valid) begin
        if (e_lat == 0) e_lat = cyc;
        resp_cnt++;
        if (resp_cnt > hold) begin resp_ready = 1; done = 1; end
      end
      if (wb_valid) begin
        wb_cnt++;
        if (wb_cnt > wb_lat) begin wb_ready = 1; wb_acc = 1; end
      end else if (wb_acc) begin
        wbd++;
        if (wbd == 2) begin wb_done = 1; wb_acc = 0; end
      end
      if (rf_valid) begin
        rf_cnt++;
        if (rf_cnt > rf_lat) begin rf_ready = 1; rf_acc = 1; end
      end else if (rf_acc) begin
        rfdc++;
        if (abort && rfdc == 1) begin
          rst = 0; rf_done = 1; busy = 0; in_rst = 1; e_abort = 1; done = 1;
        end else if (rfdc == rfd) begin
          rf_done = 1; rf_acc = 0;
        end
      end
    end
    if (!done) e_timeout = 1;
    if (e_abort) model_clear();
    else begin
      @(posedge clk);
      busy = 0;
      if (!e_timeout) commit(wen);
    end
    end_req++;
    @(negedge clk);
    resp_ready = 0; wb_ready = 0; rf_ready = 0; wb_done = 0; rf_done = 0;
    #2;
    lit_on = 0;
    if (e_abort) begin
      @(negedge clk);
      rst = 1; in_rst = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1; in_rst = 0;
    @(negedge clk);

    // Cold miss, then re-read hit.
    lit(0, 2'd0, 32'h0000_1020, 4'b0001, 7'd1, 20'h00001, 0, 0);
    txn(32'h0000_1020, 0, 0, 0, 3, 0, 0);
    lit(1, 2'd0, 0, 0, 0, 0, 0, 0);
    txn(32'h0000_1020, 0, 0, 0, 3, 0, 0);

    // Fill the rest of set 1, dirty way 0, then steer PLRU back onto way 0.
    txn(32'h0000_2020, 0, 0, 1, 1, 0, 0);
    txn(32'h0000_3020, 0, 0, 2, 2, 1, 0);
    txn(32'h0000_4020, 0, 0, 0, 1, 0, 0);
    lit(1, 2'd0, 0, 0, 0, 0, 0, 0);
    txn(32'h0000_1020, 1, 0, 0, 1, 0, 0);
    txn(32'h0000_3020, 0, 0, 0, 1, 0, 0);
    txn(32'h0000_2020, 0, 0, 0, 1, 0, 0);
    txn(32'h0000_4020, 0, 0, 0, 1, 0, 0);

    // Dirty eviction with stalled handshakes and a held response.
    lit(0, 2'd0, 32'h0000_5020, 4'b0001, 7'd1, 20'h00005, 1, 32'h0000_1020);
    txn(32'h0000_5020, 0, 10, 10, 2, 5, 0);

    // Mixed store/load misses walking the PLRU through set 1.
    txn(32'h0000_6020, 1, 1, 0, 1, 0, 0);
    txn(32'h0000_7020, 0, 0, 0, 1, 0, 0);
    txn(32'h0000_8020, 0, 0, 0, 1, 0, 0);
    txn(32'h0000_9020, 0, 0, 0, 1, 0, 0);
    txn(32'h0000_A020, 0, 2, 1, 1, 2, 0);

    // Clean PLRU eviction in set 2 after access order 0,1,2,3.
    txn(32'h0000_1040, 0, 0, 0, 1, 0, 0);
    txn(32'h0000_2040, 0, 0, 0, 1, 0, 0);
    txn(32'h0000_3040, 0, 0, 0, 1, 0, 0);
    txn(32'h0000_4040, 0, 0, 0, 1, 0, 0);
    lit(0, 2'd0, 32'h0000_5040, 4'b0001, 7'd2, 20'h00005, 0, 0);
    txn(32'h0000_5040, 0, 0, 0, 1, 0, 0);

    // Reset during RF_WAIT, then the same address must miss into way 0.
    txn(32'h0000_B020, 0, 0, 0, 3, 0, 1);
    lit(0, 2'd0, 32'h0000_B020, 4'b0001, 7'd1, 20'h0000B, 0, 0);
    txn(32'h0000_B020, 0, 0, 0, 2, 0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
